// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a byte stream into 32-bit instruction
// words, writes them to instruction memory, then releases the core.
// Ports: clk/arst_n (async active-low reset); start/num_words/halt control;
// s_valid/s_data/s_ready byte stream; addr_ext/wen_ext/ren_ext/wdata_ext
// memory write port; cpu_enable core release; busy/done/error status.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a CHECK state that compares a
// trailing little-endian 32-bit sum of the loaded words, plus the csum port.
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int MAX_WORDS = 512,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             halt,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      csum
`endif
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RUN, ERR, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RUN, ERR} state_t;
`endif
  state_t state, state_n;
  logic [1:0] byte_idx;
  logic [CNT_W-1:0] word_cnt, num_lat, word_cnt_inc;
  // bytes 0..2 of the word in flight; byte 3 arrives directly from s_data
  logic [23:0] shreg;
  logic load_ok, hs, last_byte, accept;
  assign load_ok = num_words != '0 && 32'(num_words) <= 32'(MAX_WORDS);
  assign hs = s_valid && s_ready;
  assign last_byte = hs && byte_idx == 2'd3;
  assign word_cnt_inc = word_cnt + CNT_W'(1);
  assign accept = start && load_ok && (state == IDLE || state == ERR || (state == RUN && !halt));
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ERR: state_n = start ? (load_ok ? COLLECT : ERR) : state;
      RUN:       state_n = halt ? IDLE : start ? (load_ok ? COLLECT : ERR) : RUN;
      COLLECT:   state_n = last_byte ? WRITE : COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE:     state_n = word_cnt_inc == num_lat ? CHECK : COLLECT;
      CHECK:     state_n = last_byte ? ({s_data, shreg} == csum ? RUN : ERR) : CHECK;
`else
      WRITE:     state_n = word_cnt_inc == num_lat ? RUN : COLLECT;
`endif
      default:   state_n = IDLE;
    endcase
  end
  // all status outputs decode the state register, so none has an input path
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign s_ready = state == COLLECT || state == CHECK;
  assign busy = state == COLLECT || state == WRITE || state == CHECK;
`else
  assign s_ready = state == COLLECT;
  assign busy = state == COLLECT || state == WRITE;
`endif
  assign wen_ext = state == WRITE;
  assign ren_ext = 1'b0;
  assign cpu_enable = state == RUN;
  assign error = state == ERR;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      byte_idx <= '0;
      word_cnt <= '0;
      num_lat <= '0;
      shreg <= '0;
      addr_ext <= '0;
      wdata_ext <= '0;
      done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_n;
      done <= state_n == RUN && state != RUN;
      if (hs) begin
        shreg <= {s_data, shreg[23:8]};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == COLLECT && last_byte) begin
        wdata_ext <= {s_data, shreg};
        addr_ext <= BASE_ADDR + 64'({word_cnt, 2'b00});
      end
      if (state == WRITE) word_cnt <= word_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == WRITE) csum <= csum + wdata_ext;
      if (accept) csum <= '0;
`endif
      if (accept) begin
        num_lat <= num_words;
        word_cnt <= '0;
        byte_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader
module tb_imem_loader;
  localparam logic [63:0] BASE = 64'd0;
  logic clk = 0, arst_n = 0, start = 0, halt = 0, s_valid = 0;
  logic [15:0] num_words = 0;
  logic [7:0] s_data = 0;
  logic s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
  logic [63:0] addr_ext;
  logic [31:0] wdata_ext;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif
  int checks = 0, failures = 0, done_cnt = 0;
  logic [95:0] wq[$];
  logic [7:0] bq[$];
  typedef struct {logic [15:0] n; logic exp_err; logic exp_busy;} vec_t;
  vec_t tbl[6];

  imem_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start), .num_words(num_words), .halt(halt),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .addr_ext(addr_ext),
    .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .cpu_enable(cpu_enable),
    .busy(busy), .done(done), .error(error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext) wq.push_back({addr_ext, wdata_ext});
      if (done) done_cnt++;
      checks++;
      if (cpu_enable && busy) begin
        failures++;
        $display("FAIL cpu_enable_while_busy actual=1 expected=0 at %0t", $time);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    arst_n = 0;
    start = 0;
    halt = 0;
    s_valid = 0;
    tick();
    tick();
    arst_n = 1;
    tick();
  endtask

  task automatic fill(input int n);
    bq.delete();
    for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    bit taken = 0;
    if (gaps) begin
      s_valid = 0;
      tick();
    end
    s_valid = 1;
    s_data = b;
    while (!taken && waited < 20) begin
      taken = s_ready;
      tick();
      waited++;
    end
    s_valid = 0;
    if (!taken) chk("byte_accept_timeout", 0, 1);
  endtask

  // reference: word i is bytes 4i..4i+3 little-endian, written at BASE+4i
  task automatic load(input int n, input bit gaps);
    logic [95:0] exp[$];
    logic [31:0] w, sum;
    int dc;
    sum = 0;
    wq.delete();
    dc = done_cnt;
    num_words = 16'(n);
    start = 1;
    tick();
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("cpu_off_while_loading", cpu_enable, 0);
    for (int i = 0; i < n; i++) begin
      w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      exp.push_back({BASE + 64'(4 * i), w});
      sum = sum + w;
      for (int j = 0; j < 4; j++) send_byte(bq[4*i+j], gaps);
      chk("wen_after_4th_byte", wen_ext, 1);
      chk("s_ready_low_in_write", s_ready, 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int j = 0; j < 4; j++) send_byte(sum[8*j +: 8], gaps);
`else
    tick();
`endif
    chk("done_first_run_cycle", done, 1);
    chk("cpu_enable_in_run", cpu_enable, 1);
    chk("error_low_in_run", error, 0);
    tick();
    chk("done_single_pulse", done, 0);
    chk("cpu_enable_held", cpu_enable, 1);
    chk("done_count", done_cnt - dc, 1);
    chk("write_count", wq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wq.size(); i++) chk("write_addr_data", wq[i], exp[i]);
  endtask

  initial begin
    tick();
    chk("reset_s_ready", s_ready, 0);
    chk("reset_wen", wen_ext, 0);
    chk("reset_ren", ren_ext, 0);
    chk("reset_addr", addr_ext, 0);
    chk("reset_wdata", wdata_ext, 0);
    chk("reset_status", {cpu_enable, busy, done, error}, 0);
    arst_n = 1;
    tick();

    tbl = '{'{16'd0, 1'b1, 1'b0}, '{16'd513, 1'b1, 1'b0}, '{16'hffff, 1'b1, 1'b0},
            '{16'd512, 1'b0, 1'b1}, '{16'd1, 1'b0, 1'b1}, '{16'd2, 1'b0, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      num_words = tbl[i].n;
      start = 1;
      tick();
      start = 0;
      chk($sformatf("tbl%0d_error", i), error, tbl[i].exp_err);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_cpu_wen", i), {cpu_enable, wen_ext}, 0);
    end

    do_reset();
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(2, 0);
    chk("tp1_word1", wq.size() > 1 ? wq[1] : 96'd0, {64'd4, 32'h00100093});
    do_reset();
    load(2, 1);
    chk("tp2_word0", wq.size() > 0 ? wq[0] : 96'd0, {64'd0, 32'h00000013});

    do_reset();
    wq.delete();
    num_words = 0;
    start = 1;
    tick();
    start = 0;
    chk("zero_words_error", error, 1);
    tick();
    chk("err_holds_cpu_off", {error, cpu_enable}, 2'b10);
    num_words = 513;
    start = 1;
    tick();
    start = 0;
    chk("oversize_error", error, 1);
    chk("err_no_writes", wq.size(), 0);
    fill(1);
    load(1, 0);

    wq.delete();
    halt = 1;
    start = 1;
    num_words = 1;
    tick();
    halt = 0;
    start = 0;
    chk("halt_wins_cpu_off", cpu_enable, 0);
    chk("halt_wins_idle", {busy, error, s_ready}, 0);
    repeat (3) tick();
    chk("halt_no_reload", {busy, cpu_enable, wq.size() == 0}, 3'b001);

    do_reset();
    fill(2);
    wq.delete();
    num_words = 2;
    start = 1;
    tick();
    start = 0;
    for (int j = 0; j < 6; j++) send_byte(bq[j], 0);
    chk("midload_word0_only", wq.size(), 1);
    chk("midload_word0", wq.size() > 0 ? wq[0] : 96'd0, {BASE, bq[3], bq[2], bq[1], bq[0]});
    arst_n = 0;
    #1;
    chk("async_reset_ports", {s_ready, wen_ext, cpu_enable, busy, done, error}, 0);
    chk("async_reset_bus", {addr_ext, wdata_ext}, 0);
    tick();
    arst_n = 1;
    s_valid = 1;
    s_data = 8'h5a;
    repeat (6) tick();
    chk("post_reset_idle", {s_ready, busy}, 0);
    s_valid = 0;
    chk("post_reset_no_writes", wq.size(), 1);

    for (int it = 0; it < 12; it++) begin
      int r, n;
      r = $urandom_range(0, 3);
      n = $urandom_range(1, 6);
      if (r == 0) begin
        num_words = ($urandom % 2) ? 16'd0 : 16'($urandom_range(513, 2000));
        start = 1;
        tick();
        start = 0;
        chk("rand_bad_count_error", {error, cpu_enable, busy}, 3'b100);
      end else begin
        if (r == 1 && cpu_enable) begin
          halt = 1;
          tick();
          halt = 0;
          chk("rand_halt_cpu_off", cpu_enable, 0);
        end
        fill(n);
        load(n, 1'($urandom % 2));
      end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(2, 0);
    chk("csum_value", csum, 32'h001000a6);
    halt = 1;
    tick();
    halt = 0;
    num_words = 2;
    start = 1;
    tick();
    start = 0;
    for (int j = 0; j < 8; j++) send_byte(bq[j], 0);
    send_byte(8'ha7, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    chk("csum_mismatch_error", {error, cpu_enable, done}, 3'b100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream boot block for the pipelined RISC-V core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through the core's external port (addr_ext/wen_ext/wdata_ext), then releases the core by asserting its enable.
- Returns the core to halt on request, ready for a reload.

Parameters:
- BASE_ADDR, 0, byte address of the first word written.
- MAX_WORDS, 512, capacity of instruction memory in words; larger loads are rejected.
- CNT_W, 16, width of num_words and the internal word counter.

Ports:
- clk  input  1  clock
- arst_n  input  1  asynchronous reset, active low
- start  input  1  one-cycle request to begin a load; sampled only in IDLE/RUN/ERR
- num_words  input  CNT_W  word count for the load, sampled when start is accepted
- halt  input  1  in RUN: drop cpu_enable and return to IDLE
- s_valid  input  1  byte stream valid
- s_data  input  8  byte stream data
- s_ready  output  1  byte accepted when s_valid && s_ready
- addr_ext  output  64  instruction memory external address (byte address)
- wen_ext  output  1  instruction memory external write enable
- ren_ext  output  1  tied 0
- wdata_ext  output  32  instruction word
- cpu_enable  output  1  drives core enable
- busy  output  1  high in COLLECT/WRITE
- done  output  1  one-cycle pulse on entry to RUN
- error  output  1  high in ERR

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; byte index, word counter and shift register all 0.
  - Reset mid-load abandons the partial word; nothing further is written.
- States: IDLE, COLLECT, WRITE, RUN, ERR.
- IDLE:
  - start && num_words==0 -> ERR.
  - start && num_words>MAX_WORDS -> ERR.
  - Otherwise start -> COLLECT; latch num_words; clear word_cnt and byte_idx.
- COLLECT:
  - s_ready=1.
  - Each handshake writes s_data into byte lane byte_idx: lane 0 is [7:0] (first byte received), lane 3 is [31:24].
  - byte_idx increments mod 4.
  - The handshake that fills lane 3 moves to WRITE.
  - start and halt are ignored.
- WRITE (exactly one cycle):
  - s_ready=0, wen_ext=1, wdata_ext=assembled word.
  - addr_ext=BASE_ADDR + 4*word_cnt (64-bit, no wrap, since word_cnt<MAX_WORDS).
  - word_cnt increments.
  - If the new word_cnt == latched num_words -> RUN, else -> COLLECT.
- Outputs are registered:
  - wen_ext is high in the cycle after the 4th byte handshake.
  - Minimum 5 cycles per word with continuous s_valid.
- Outside WRITE, wen_ext=0; addr_ext and wdata_ext hold their last values.
- RUN:
  - cpu_enable=1 (registered; high from the first RUN cycle).
  - done pulses in the first RUN cycle only.
  - halt -> IDLE; cpu_enable is 0 in the following cycle.
  - start without halt -> COLLECT (reload), with the same checks as IDLE; cpu_enable drops the cycle COLLECT is entered.
  - If halt and start are both asserted, halt wins.
- ERR:
  - error=1, cpu_enable=0.
  - Only start leaves ERR, with the same checks as IDLE.
- The stream must not stall the core: cpu_enable is never 1 while busy=1.
- s_valid while s_ready=0 is held by the source; no byte is dropped.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A 32-bit running sum (mod 2^32) accumulates every word written.
  - After the last WRITE, the FSM enters CHECK instead of RUN.
  - CHECK collects 4 more bytes (little-endian) as the expected sum; no memory write occurs.
  - Match -> RUN; mismatch -> ERR.
  - The sum clears when start is accepted.
  - Extra output port csum  output  32  current running sum.
- When undefined: no CHECK state, no csum port; last WRITE goes straight to RUN.

Test Plan:
- Reset, then start with num_words=2 and bytes 13 00 00 00 93 00 10 00 (continuous valid) -> writes 0x00000013 @0x0 then 0x00100093 @0x4; wen_ext exactly 2 cycles; done pulse; cpu_enable=1.
- Same load with s_valid toggled every other cycle -> identical writes; s_ready low during each WRITE; no byte lost.
- start with num_words=0, then separately num_words=513 -> error=1, no wen_ext, cpu_enable=0; subsequent start with num_words=1 recovers.
- In RUN, assert halt and start in the same cycle -> IDLE; cpu_enable=0 next cycle; no reload.
- Deassert arst_n after 6 bytes of a 2-word load -> all outputs 0 immediately; only word 0 written; after release, IDLE with no further writes.
- With IMEM_LOADER_CHECKSUM_EN: load words 0x00000013 and 0x00100093, then checksum bytes A6 00 10 00 -> RUN. Same load with checksum A7 00 10 00 -> ERR.
